// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store unit: byte-enabled loads and stores on a
// single-port word array, including unaligned and word-crossing accesses.
// Latency: load response 2 cycles after accept (3 if it crosses a word); stores give no response.
// Backpressure: ready only in IDLE; a stalled response holds all outputs and blocks new requests.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   to_mem_valid/ready        request handshake
//   to_mem_rs_id/reg_addr     request tags, returned with the load response
//   mem_address               byte address (big-endian bit 0 is the MSB, i.e. [31] here)
//   mem_write_en/_data        store lane mask and left-justified store data
//   mem_read_en               load lane mask
//   from_mem_valid/ready      response handshake
//   from_mem_rs_id/reg_addr   response tags
//   mem_read_data             load data, right-justified, zero-extended
//
// Big-endian lane j (bits [8j:8j+7] in the 0..31 numbering) is held in [31-8j -: 8]
// of these descending vectors, so lane 0 (lowest address) is the top byte. Lane masks
// keep lane 0 in bit [3], which makes 4'b1000 a byte, 4'b1100 a half, 4'b1111 a word.
module data_mem_responder #(
  parameter int RS_ID_WIDTH = 5,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   to_mem_valid,
  output logic                   to_mem_ready,
  input  logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
  input  logic [4:0]             to_mem_reg_addr,
  input  logic [31:0]            mem_address,
  input  logic [3:0]             mem_write_en,
  input  logic [31:0]            mem_write_data,
  input  logic [3:0]             mem_read_en,
  output logic                   from_mem_valid,
  input  logic                   from_mem_ready,
  output logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
  output logic [4:0]             from_mem_reg_addr,
  output logic [31:0]            mem_read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] WORD_ONE = 1;

  typedef enum logic [2:0] {IDLE, ST2, LD_A, LD_B, RESP} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_q;

  // Request fields latched at accept
  logic [1:0]            q_off;
  logic [ADDR_WIDTH-1:0] q_widx;
  logic [3:0]            q_rmask;
  logic [31:0]           q_wd1;
  logic [3:0]            q_be1;
  logic [31:0]           q_w0;

  function automatic logic legal_mask(input logic [3:0] m);
    return (m == 4'b1000) || (m == 4'b1100) || (m == 4'b1111);
  endfunction

  // Picks bytes off..off+n-1 out of the word pair {w0, w1} and right-justifies them.
  function automatic logic [31:0] assemble(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [1:0] off, input logic [3:0] m);
    logic [63:0] cat;
    logic [5:0]  rsh;
    cat = {w0, w1} << {off, 3'b000};
    case (m)
      4'b1000: rsh = 6'd24;
      4'b1100: rsh = 6'd16;
      default: rsh = 6'd0;
    endcase
    return cat[63:32] >> rsh;
  endfunction

  logic                  accept;
  logic                  is_store;
  logic                  is_load;
  logic [1:0]            in_off;
  logic [ADDR_WIDTH-1:0] in_widx;
  logic [7:0]            in_be;
  logic [63:0]           in_wd;
  logic [7:0]            rm_sh;
  logic                  ld_cross;
  logic                  addr_unused;

  assign to_mem_ready = (state == IDLE) && !rst;
  assign accept       = to_mem_valid && to_mem_ready;
  assign is_store     = (|mem_write_en) && legal_mask(mem_write_en);
  assign is_load      = !(|mem_write_en) && legal_mask(mem_read_en);

  assign in_off      = mem_address[1:0];
  assign in_widx     = mem_address[ADDR_WIDTH+1:2];
  // Address bits above the array size are ignored, so accesses wrap modulo DEPTH.
  assign addr_unused = ^mem_address[31:ADDR_WIDTH+2];

  // Sliding the lane mask/data down by the byte offset spreads the store over two
  // words: the upper half targets word W, the lower half (if nonzero) word W+1.
  assign in_be = {mem_write_en, 4'b0000} >> in_off;
  assign in_wd = {mem_write_data, 32'h0} >> {in_off, 3'b000};

  // The same slide applied to the load mask shows whether the load spills into W+1.
  assign rm_sh    = {q_rmask, 4'b0000} >> q_off;
  assign ld_cross = |rm_sh[3:0];

  // Single memory port: one write and/or one read address per cycle
  logic                  we;
  logic [ADDR_WIDTH-1:0] wi;
  logic [3:0]            wbe;
  logic [31:0]           wdat;
  logic                  re;
  logic [ADDR_WIDTH-1:0] ri;

  always_comb begin
    we   = 1'b0;
    wi   = in_widx;
    wbe  = in_be[7:4];
    wdat = in_wd[63:32];
    re   = 1'b0;
    ri   = in_widx;
    if (!rst) begin
      case (state)
        IDLE: begin
          we = accept && is_store;
          re = accept && is_load;
        end
        ST2: begin
          // Gated by rst above, so a reset here leaves only the first word written.
          we   = 1'b1;
          wi   = q_widx + WORD_ONE;
          wbe  = q_be1;
          wdat = q_wd1;
        end
        LD_A: begin
          re = ld_cross;
          ri = q_widx + WORD_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[wi][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
    if (re) rd_q <= mem[ri];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      from_mem_valid    <= 1'b0;
      from_mem_rs_id    <= '0;
      from_mem_reg_addr <= '0;
      mem_read_data     <= '0;
      q_off             <= '0;
      q_widx            <= '0;
      q_rmask           <= '0;
      q_wd1             <= '0;
      q_be1             <= '0;
      q_w0              <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            q_off   <= in_off;
            q_widx  <= in_widx;
            q_rmask <= mem_read_en;
            q_wd1   <= in_wd[31:0];
            q_be1   <= in_be[3:0];
            if (is_store && (|in_be[3:0])) begin
              state <= ST2;
            end else if (is_load) begin
              from_mem_rs_id    <= to_mem_rs_id;
              from_mem_reg_addr <= to_mem_reg_addr;
              state             <= LD_A;
            end
            // Illegal or empty masks are swallowed: stay in IDLE, no response.
          end
        end
        ST2: state <= IDLE;
        LD_A: begin
          if (ld_cross) begin
            q_w0  <= rd_q;
            state <= LD_B;
          end else begin
            mem_read_data  <= assemble(rd_q, 32'h0, q_off, q_rmask);
            from_mem_valid <= 1'b1;
            state          <= RESP;
          end
        end
        LD_B: begin
          mem_read_data  <= assemble(q_w0, rd_q, q_off, q_rmask);
          from_mem_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (from_mem_ready) begin
            from_mem_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios followed by random traffic,
// checked against a byte-addressed memory model.
module tb_data_mem_responder;

  localparam int RSW   = 5;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BMASK = 4 * DEPTH - 1;

  logic           clk;
  logic           rst;
  logic           to_mem_valid;
  logic           to_mem_ready;
  logic [RSW-1:0] to_mem_rs_id;
  logic [4:0]     to_mem_reg_addr;
  logic [31:0]    mem_address;
  logic [3:0]     mem_write_en;
  logic [31:0]    mem_write_data;
  logic [3:0]     mem_read_en;
  logic           from_mem_valid;
  logic           from_mem_ready;
  logic [RSW-1:0] from_mem_rs_id;
  logic [4:0]     from_mem_reg_addr;
  logic [31:0]    mem_read_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl [4*DEPTH];

  data_mem_responder #(.RS_ID_WIDTH(RSW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .to_mem_valid(to_mem_valid), .to_mem_ready(to_mem_ready),
    .to_mem_rs_id(to_mem_rs_id), .to_mem_reg_addr(to_mem_reg_addr),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .from_mem_valid(from_mem_valid), .from_mem_ready(from_mem_ready),
    .from_mem_rs_id(from_mem_rs_id), .from_mem_reg_addr(from_mem_reg_addr),
    .mem_read_data(mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [3:0] m);
    case (m)
      4'b1000: return 1;
      4'b1100: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    for (int k = 0; k < nbytes(we); k++)
      mdl[(a + 32'(k)) & BMASK] = wd[31-8*k -: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < nbytes(m); k++)
      r = {r[23:0], mdl[(a + 32'(k)) & BMASK]};
    return r;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [3:0] m);
    return ((int'(a[1:0]) + nbytes(m)) > 4) ? 3 : 2;
  endfunction

  // Presents a request and returns one cycle after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic [3:0] re, input logic [4:0] rs, input logic [4:0] ra);
    int n;
    to_mem_valid = 1'b1; mem_address = a; mem_write_en = we; mem_write_data = wd;
    mem_read_en = re; to_mem_rs_id = rs; to_mem_reg_addr = ra;
    n = 0;
    while (!to_mem_ready && n < 50) begin step(); n++; end
    check("accept_wait", {31'b0, to_mem_ready}, 32'd1);
    step();
    to_mem_valid = 1'b0;
    if (we != 4'b0000) model_store(a, we, wd);
  endtask

  // Waits for a response (from one cycle after accept), holds ready low for 'stall'
  // cycles, then completes the handshake and checks that valid drops.
  task automatic get_resp(input int stall, output logic [31:0] d, output logic [4:0] rs,
                          output logic [4:0] ra, output int lat);
    lat = 1;
    from_mem_ready = 1'b0;
    while (!from_mem_valid && lat < 20) begin step(); lat++; end
    check("resp_wait", {31'b0, from_mem_valid}, 32'd1);
    d = mem_read_data; rs = from_mem_rs_id; ra = from_mem_reg_addr;
    repeat (stall) step();
    from_mem_ready = 1'b1;
    step();
    from_mem_ready = 1'b0;
    check("valid_drop", {31'b0, from_mem_valid}, 32'd0);
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [3:0] m,
                            input int stall);
    logic [31:0] d;
    logic [4:0]  rs, ra, ers, era;
    int          lat;
    ers = 5'($urandom); era = 5'($urandom);
    send(a, 4'b0000, 32'h0, m, ers, era);
    get_resp(stall, d, rs, ra, lat);
    check(tag, d, model_load(a, m));
    check("rs_id", 32'(rs), 32'(ers));
    check("reg_addr", 32'(ra), 32'(era));
    check("latency", 32'(lat), 32'(exp_lat(a, m)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, a, wd;
    logic [3:0]  m;
    logic [7:0]  save0, save1;
    logic [3:0]  masks [3];
    masks[0] = 4'b1000; masks[1] = 4'b1100; masks[2] = 4'b1111;

    rst = 1'b1; to_mem_valid = 1'b0; to_mem_rs_id = '0; to_mem_reg_addr = '0;
    mem_address = '0; mem_write_en = '0; mem_write_data = '0; mem_read_en = '0;
    from_mem_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_ready", {31'b0, to_mem_ready}, 32'd0);
    check("rst_valid", {31'b0, from_mem_valid}, 32'd0);
    check("rst_rs_id", 32'(from_mem_rs_id), 32'd0);
    check("rst_reg_addr", 32'(from_mem_reg_addr), 32'd0);
    check("rst_data", mem_read_data, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", {31'b0, to_mem_ready}, 32'd1);
    step();

    // Aligned word store then load
    send(32'h10, 4'b1111, 32'hDEADBEEF, 4'b0000, 5'd0, 5'd0);
    check("store_nocross_ready", {31'b0, to_mem_ready}, 32'd1);
    load_check("word_load", 32'h10, 4'b1111, 0);
    check("word_load_const", model_load(32'h10, 4'b1111), 32'hDEADBEEF);

    // Byte store into last lane
    send(32'h13, 4'b1000, 32'hAB000000, 4'b0000, 5'd0, 5'd0);
    load_check("byte_merge", 32'h10, 4'b1111, 0);
    check("byte_merge_const", model_load(32'h10, 4'b1111), 32'hDEADBEAB);
    load_check("byte_load", 32'h13, 4'b1000, 0);

    // Crossing half load
    send(32'h10, 4'b1111, 32'h11223344, 4'b0000, 5'd0, 5'd0);
    send(32'h14, 4'b1111, 32'h55667788, 4'b0000, 5'd0, 5'd0);
    load_check("cross_half", 32'h13, 4'b1100, 0);
    check("cross_half_const", model_load(32'h13, 4'b1100), 32'h00004455);

    // Crossing word store
    send(32'h16, 4'b1111, 32'hCAFEF00D, 4'b0000, 5'd0, 5'd0);
    check("cross_store_busy", {31'b0, to_mem_ready}, 32'd0);
    step();
    check("cross_store_done", {31'b0, to_mem_ready}, 32'd1);
    load_check("cross_store_w0", 32'h14, 4'b1111, 0);
    check("cross_store_w0_const", model_load(32'h14, 4'b1111), 32'h5566CAFE);
    load_check("cross_store_b18", 32'h18, 4'b1000, 0);
    load_check("cross_store_b19", 32'h19, 4'b1000, 0);
    check("cross_store_half_const", model_load(32'h18, 4'b1100), 32'h0000F00D);

    // Stalled response blocks a new request
    send(32'h10, 4'b0000, 32'h0, 4'b1111, 5'd9, 5'd17);
    for (int n = 0; n < 20 && !from_mem_valid; n++) step();
    d0 = mem_read_data;
    check("stall_data0", d0, 32'h11223344);
    to_mem_valid = 1'b1; mem_address = 32'h20; mem_write_en = 4'b1111;
    mem_write_data = 32'h12345678; mem_read_en = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, from_mem_valid}, 32'd1);
      check("stall_data", mem_read_data, d0);
      check("stall_rs_id", 32'(from_mem_rs_id), 32'd9);
      check("stall_reg_addr", 32'(from_mem_reg_addr), 32'd17);
      check("stall_ready", {31'b0, to_mem_ready}, 32'd0);
      step();
    end
    from_mem_ready = 1'b1;
    step();
    from_mem_ready = 1'b0;
    check("stall_valid_drop", {31'b0, from_mem_valid}, 32'd0);
    check("stall_ready_back", {31'b0, to_mem_ready}, 32'd1);
    step();
    to_mem_valid = 1'b0;
    model_store(32'h20, 4'b1111, 32'h12345678);
    load_check("after_stall_store", 32'h20, 4'b1111, 0);

    // Reset while the response is pending
    send(32'h10, 4'b0000, 32'h0, 4'b1111, 5'd3, 5'd4);
    for (int n = 0; n < 20 && !from_mem_valid; n++) step();
    check("pre_rst_valid", {31'b0, from_mem_valid}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_valid", {31'b0, from_mem_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, to_mem_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'b0, to_mem_ready}, 32'd1);
    from_mem_ready = 1'b1;
    repeat (3) begin
      step();
      check("post_rst_no_resp", {31'b0, from_mem_valid}, 32'd0);
    end
    from_mem_ready = 1'b0;

    // Illegal / empty masks are no-ops
    send(32'h10, 4'b0000, 32'h0, 4'b1010, 5'd1, 5'd1);
    check("noop_read_ready", {31'b0, to_mem_ready}, 32'd1);
    send(32'h10, 4'b1010, 32'hFFFFFFFF, 4'b0000, 5'd1, 5'd1);
    send(32'h10, 4'b0000, 32'h0, 4'b0000, 5'd1, 5'd1);
    // A legal store with a read mask present is still only a store
    send(32'h24, 4'b1111, 32'h0BADF00D, 4'b1111, 5'd1, 5'd1);
    from_mem_ready = 1'b1;
    repeat (3) begin
      step();
      check("noop_no_resp", {31'b0, from_mem_valid}, 32'd0);
    end
    from_mem_ready = 1'b0;
    load_check("noop_unchanged", 32'h10, 4'b1111, 0);
    load_check("store_with_re", 32'h24, 4'b1111, 0);

    // Reset during the second half of a crossing store: only the first word lands
    save0 = mdl[32'h20]; save1 = mdl[32'h21];
    send(32'h1E, 4'b1111, 32'hA1B2C3D4, 4'b0000, 5'd0, 5'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl[32'h20] = save0; mdl[32'h21] = save1;
    step();
    load_check("rst_cross_w1", 32'h20, 4'b1111, 0);
    load_check("rst_cross_w0", 32'h1C, 4'b1111, 0);

    // Random traffic over words 0..15 and the top word (wrap into word 0)
    for (int w = 0; w < 16; w++)
      send(32'(4*w), 4'b1111, $urandom, 4'b0000, 5'd0, 5'd0);
    send(32'(4*(DEPTH-1)), 4'b1111, $urandom, 4'b0000, 5'd0, 5'd0);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) a = 32'(4*DEPTH - 4) + 32'($urandom_range(0, 3));
      else                           a = 32'($urandom_range(0, 59));
      a = a | ($urandom << (AW + 2));
      m  = masks[$urandom_range(0, 2)];
      wd = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        send(a, m, wd, 4'($urandom), 5'($urandom), 5'($urandom));
        if (to_mem_ready == 1'b0) step();
      end else begin
        load_check("rand_load", a, m, $urandom_range(0, 3));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
